a51_keystream_ctrl: RTL

//  Sequences one A5/1 LFSR core (R1/R2/R3 = 19/22/23 bits) through a full GSM frame session.
//  Per session: clear, key load, frame-number load, discarded mixing, then 228 keystream bits
//  (114 downlink followed by 114 uplink) delivered on a valid/ready stream.

---
 rtl/a51_pkg.sv | 37 +++
 rtl/a51_if.sv | 36 +++
 rtl/a51_load_shifter.sv | 37 +++
 rtl/a51_keystream_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared constants, state encoding and key/frame bit ordering for the A5/1 keystream controller.
package a51_pkg;

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;
  localparam int MIX_CYCLES = 100;
  localparam int KS_BITS    = 228;
  localparam int LOAD_BITS  = KEY_BITS + FRAME_BITS;
  localparam int CNT_W      = $clog2(KS_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_KEY,
    LOAD_FRAME,
    MIX,
    RUN
  } a51_state_t;

  // The key word carries key byte 0 in its top byte [63:56]; bytes are fed in
  // order 0..7 and each byte LSB first, so load bit i is byte i/8, bit i%8.
  function automatic logic [KEY_BITS-1:0] keyLoadOrder(input logic [KEY_BITS-1:0] key);
    logic [KEY_BITS-1:0] ordered;
    ordered = '0;
    for (int i = 0; i < KEY_BITS; i++) begin
      ordered[i] = key[8*(KEY_BITS/8 - 1 - i/8) + (i % 8)];
    end
    return ordered;
  endfunction

  // Frame number is fed plainly LSB first, after all key bits.
  function automatic logic [LOAD_BITS-1:0] loadWord(input logic [KEY_BITS-1:0] key,
                                                     input logic [FRAME_BITS-1:0] frame);
    return {frame, keyLoadOrder(key)};
  endfunction

endpackage

// File: rtl/a51_if.sv
// Session, keystream and cipher-core signals of the A5/1 keystream controller.
// The master side is the environment (front end, consumer, core); the slave side is the controller.
interface a51_if;
  import a51_pkg::*;

  logic                  start;
  logic [KEY_BITS-1:0]   key;
  logic [FRAME_BITS-1:0] frame;
  logic                  abort;
  logic                  ready;
  logic                  busy;
  logic                  ks_valid;
  logic                  ks_ready;
  logic                  ks_bit;
  logic                  ks_dir;
  logic                  ks_last;
  logic                  done;
  logic                  core_clr;
  logic                  core_step;
  logic                  core_force;
  logic                  core_din;
  logic                  core_ks_bit;

  modport master (
    output start, key, frame, abort, ks_ready, core_ks_bit,
    input  ready, busy, ks_valid, ks_bit, ks_dir, ks_last, done,
           core_clr, core_step, core_force, core_din
  );

  modport slave (
    input  start, key, frame, abort, ks_ready, core_ks_bit,
    output ready, busy, ks_valid, ks_bit, ks_dir, ks_last, done,
           core_clr, core_step, core_force, core_din
  );

endinterface

// File: rtl/a51_load_shifter.sv
// Holds the latched key and frame bits and presents them one per load step, LSB first.
module a51_load_shifter
  import a51_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [LOAD_BITS-1:0] data_i,
  output logic                 bit_o
);

  logic [LOAD_BITS-1:0] shift_q;
  logic [LOAD_BITS-1:0] shift_d;

  // Parallel load on session accept takes priority; otherwise shift down once per load step.
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[LOAD_BITS-1:1]};
    end
  end

  // Shadow register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_o = shift_q[0];

endmodule

// File: rtl/a51_keystream_ctrl.sv
// Session sequencer for one bit-serial A5/1 core: clear, key load, frame load,
// discarded mixing, then the downlink/uplink keystream on a valid/ready stream.
module a51_keystream_ctrl
  import a51_pkg::*;
(
  input logic clock,
  input logic reset,
  a51_if.slave bus
);

  a51_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  logic                 accept;
  logic                 inRun;
  logic                 loadStep;
  logic                 xfer;
  logic                 shiftBit;
  logic [LOAD_BITS-1:0] sessionWord;

  assign accept      = (state_q == IDLE) && bus.start && !bus.abort;
  assign inRun       = (state_q == RUN);
  assign loadStep    = (state_q == LOAD_KEY) || (state_q == LOAD_FRAME);
  assign xfer        = inRun && bus.ks_ready && !bus.abort;
  assign sessionWord = loadWord(bus.key, bus.frame);

  a51_load_shifter u_shifter (
    .clock   (clock),
    .reset   (reset),
    .load_i  (accept),
    .shift_i (loadStep),
    .data_i  (sessionWord),
    .bit_o   (shiftBit)
  );

  // Phase sequencing with a single shared counter: load/mix phases count down to 0,
  // RUN counts transferred bits up to KS_BITS-1; every state entry reloads it.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = CLEAR;
            count_d = '0;
          end
        end
        CLEAR: begin
          state_d = LOAD_KEY;
          count_d = CNT_W'(KEY_BITS - 1);
        end
        LOAD_KEY: begin
          if (count_q == '0) begin
            state_d = LOAD_FRAME;
            count_d = CNT_W'(FRAME_BITS - 1);
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        LOAD_FRAME: begin
          if (count_q == '0) begin
            state_d = MIX;
            count_d = CNT_W'(MIX_CYCLES - 1);
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        MIX: begin
          if (count_q == '0) begin
            state_d = RUN;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        RUN: begin
          if (xfer) begin
            if (count_q == CNT_W'(KS_BITS - 1)) begin
              state_d = IDLE;
              count_d = '0;
              done_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Stream and core-control outputs; the keystream fields are held at 0 outside RUN.
  always_comb begin
    bus.ready      = (state_q == IDLE);
    bus.busy       = (state_q != IDLE);
    bus.ks_valid   = inRun && !bus.abort;
    bus.ks_bit     = inRun && bus.core_ks_bit;
    bus.ks_dir     = inRun && (count_q >= CNT_W'(KS_BITS / 2));
    bus.ks_last    = inRun && (count_q == CNT_W'(KS_BITS - 1));
    bus.done       = done_q;
    bus.core_clr   = (state_q == CLEAR);
    bus.core_step  = loadStep || (state_q == MIX) || (inRun && bus.ks_ready);
    bus.core_force = loadStep;
    bus.core_din   = loadStep && shiftBit;
  end

  // State, counter and done pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule
